// File: rtl/alu_pkg.sv
// Shared ALU definitions for the digit read/write paths: widths, state encoding
// and the accumulator magnitude saturation helper.
package alu_pkg;

    localparam int ACC_W      = 11;
    localparam int ACC_MAX    = 999;
    localparam int BCD_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Widen by one bit before negating so -2**(ACC_W-1) still has a valid magnitude.
    function automatic logic [ACC_W-1:0] sat_mag(input logic [ACC_W-1:0] acc,
                                                  input logic [ACC_W-1:0] max_mag);
        logic [ACC_W:0] ext;
        logic [ACC_W:0] mag;
        ext = {acc[ACC_W-1], acc};
        if (acc[ACC_W-1]) begin
            mag = ~ext + {{ACC_W{1'b0}}, 1'b1};
        end else begin
            mag = ext;
        end
        if (mag > {1'b0, max_mag}) begin
            mag = {1'b0, max_mag};
        end else begin
            mag = mag;
        end
        return mag[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/dgt_seq_if.sv
// Start/busy/done handshake between the instruction sequencer and the digit-read unit.
interface dgt_seq_if #(parameter int WIDTH = alu_pkg::ACC_W);

    logic             start;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] arg1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    modport master (output start, output acc, output arg1,
                    input  busy,  input  done, input  out);

    modport slave  (input  start, input  acc,  input  arg1,
                    output busy,  output done, output out);

endinterface

// File: rtl/dd_step.sv
// One combinational double-dabble iteration: add-3 correction on every BCD nibble,
// then shift {bcd, bin} left by one bit.
module dd_step #(
    parameter int WIDTH  = 11,
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic [WIDTH-1:0]    bin_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic [WIDTH-1:0]    bin_o
);

    logic [4*DIGITS-1:0] corr_s;
    logic                unused_msb_s;

    // Add-3 correction for nibbles that would exceed 9 after doubling.
    always_comb begin
        corr_s = bcd_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                corr_s[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end else begin
                corr_s[4*i +: 4] = bcd_i[4*i +: 4];
            end
        end
    end

    // The top BCD bit is always zero for in-range magnitudes.
    assign {unused_msb_s, bcd_o, bin_o} = {corr_s, bin_i, 1'b0};

endmodule

// File: rtl/dgt_seq.sv
// Sequential digit-read unit: returns signed decimal digit arg1 of acc using an
// iterative double-dabble conversion of the saturated magnitude, one bit per clock.
module dgt_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = ACC_W,
    parameter int DIGITS  = BCD_DIGITS,
    parameter int ACC_MAX = alu_pkg::ACC_MAX
) (
    input  logic        clk,
    input  logic        rst,
    dgt_seq_if.slave    bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   mag_q,    mag_d;
    logic [BCD_W-1:0]   bcd_q,    bcd_d;
    logic               sign_q,   sign_d;
    logic               idx_ok_q, idx_ok_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   out_q,    out_d;

    logic [BCD_W-1:0]   bcd_nx_s;
    logic [WIDTH-1:0]   mag_nx_s;
    logic [3:0]         digit_s;
    logic [WIDTH-1:0]   digit_ext_s;

    dd_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_dd_step (
        .bcd_i (bcd_q),
        .bin_i (mag_q),
        .bcd_o (bcd_nx_s),
        .bin_o (mag_nx_s)
    );

    // Select the requested BCD nibble once conversion is complete.
    always_comb begin
        digit_s = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_s = bcd_q[4*i +: 4];
            end else begin
                digit_s = digit_s;
            end
        end
        digit_ext_s = {{(WIDTH-4){1'b0}}, digit_s};
    end

    // Next-state logic for the conversion FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        sign_d   = sign_q;
        idx_ok_d = idx_ok_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        out_d    = out_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mag_d    = sat_mag(bus.acc, WIDTH'(ACC_MAX));
                    sign_d   = bus.acc[WIDTH-1];
                    idx_ok_d = ~bus.arg1[WIDTH-1] && (bus.arg1 < WIDTH'(DIGITS));
                    idx_d    = bus.arg1[IDX_W-1:0];
                    bcd_d    = {BCD_W{1'b0}};
                    cnt_d    = CNT_W'(WIDTH - 1);
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                mag_d = mag_nx_s;
                bcd_d = bcd_nx_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                // Negating a zero digit yields zero, so -0 needs no special case.
                if (!idx_ok_q) begin
                    out_d = {WIDTH{1'b0}};
                end else if (sign_q) begin
                    out_d = {WIDTH{1'b0}} - digit_ext_s;
                end else begin
                    out_d = digit_ext_s;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_q    <= {WIDTH{1'b0}};
            bcd_q    <= {BCD_W{1'b0}};
            sign_q   <= 1'b0;
            idx_ok_q <= 1'b0;
            idx_q    <= {IDX_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            bcd_q    <= bcd_d;
            sign_q   <= sign_d;
            idx_ok_q <= idx_ok_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_q    <= out_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;

endmodule

// File: tb/tb_dgt_seq.sv
// Directed bench for dgt_seq: hand-computed digit results, latency, busy/done
// handshake, ignored starts, back-to-back starts and reset mid-conversion.
module tb_dgt_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dgt_seq_if #(.WIDTH(11)) bus_if ();

    dgt_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance one edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus_if.done && n < 40);
    endtask

    // Launch one operation from idle, check busy, latency and result.
    task automatic do_op(input string tag, input int acc, input int arg1, input int exp);
        int          n;
        logic [10:0] e;
        e = exp[10:0];
        bus_if.start = 1'b1;
        bus_if.acc   = acc[10:0];
        bus_if.arg1  = arg1[10:0];
        tick();
        bus_if.start = 1'b0;
        bus_if.acc   = 11'h2AA;
        bus_if.arg1  = 11'd0;
        check_eq({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
        wait_done(n);
        check_eq({tag, "_lat"}, 32'(n), 32'd12);
        check_eq({tag, "_out"}, 32'(bus_if.out), 32'(e));
        check_eq({tag, "_busy_off"}, 32'(bus_if.busy), 32'd0);
        tick();
        check_eq({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        total = 0;
        bad   = 0;
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.acc   = 11'd0;
        bus_if.arg1  = 11'd0;
        tick();
        tick();
        check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
        check_eq("rst_done", 32'(bus_if.done), 32'd0);
        check_eq("rst_out",  32'(bus_if.out),  32'd0);
        rst = 1'b0;
        tick();

        do_op("t472_1",   472,   1,  7);
        do_op("tm305_0",  -305,  0, -5);
        do_op("tm305_1",  -305,  1,  0);
        do_op("t1023_2",  1023,  2,  9);
        do_op("tm1024_0", -1024, 0, -9);
        do_op("tm1024_2", -1024, 2, -9);
        do_op("t123_3",   123,   3,  0);
        do_op("t123_m1",  123,  -1,  0);
        do_op("t0_0",     0,     0,  0);
        do_op("tm40_0",   -40,   0,  0);
        do_op("t999_1",   999,   1,  9);

        // Start while busy is ignored.
        bus_if.start = 1'b1;
        bus_if.acc   = 11'd888;
        bus_if.arg1  = 11'd2;
        tick();
        bus_if.start = 1'b0;
        tick();
        tick();
        tick();
        bus_if.start = 1'b1;
        bus_if.acc   = 11'd111;
        bus_if.arg1  = 11'd0;
        tick();
        bus_if.start = 1'b0;
        wait_done(n);
        check_eq("busy_ign_lat", 32'(n), 32'd8);
        check_eq("busy_ign_out", 32'(bus_if.out), 32'd8);

        // Start accepted in the done cycle.
        bus_if.start = 1'b1;
        bus_if.acc   = 11'd456;
        bus_if.arg1  = 11'd0;
        tick();
        bus_if.start = 1'b0;
        check_eq("b2b_busy", 32'(bus_if.busy), 32'd1);
        wait_done(n);
        check_eq("b2b_lat", 32'(n), 32'd12);
        check_eq("b2b_out", 32'(bus_if.out), 32'd6);
        tick();

        // Reset mid-conversion abandons the result.
        bus_if.start = 1'b1;
        bus_if.acc   = 11'd472;
        bus_if.arg1  = 11'd0;
        tick();
        bus_if.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(bus_if.busy), 32'd0);
        check_eq("midrst_done", 32'(bus_if.done), 32'd0);
        check_eq("midrst_out",  32'(bus_if.out),  32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_if.done) pulses++;
        end
        check_eq("midrst_no_done", 32'(pulses), 32'd0);
        do_op("tm57_1", -57, 1, -5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
